// File: rtl/mem_dump_pkg.sv
// mem_dump_pkg: shared types and helpers for the memory dump reader.
// Optional macro DUMP_CHECKSUM_EN adds the CSUM state to the state encoding.
package mem_dump_pkg;

    localparam int BYTE_W = 8;

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd5
    } state_t;
`endif

    // Number of bytes carried by one memory word (DATA_WIDTH is a multiple of 8).
    function automatic int bytes_per_word(input int data_width);
        return data_width / BYTE_W;
    endfunction

endpackage

// File: rtl/word_serializer.sv
// word_serializer: loads one memory word and streams it out LSB byte first
// over a valid/ready handshake; flags acceptance of the final byte.
import mem_dump_pkg::*;

module word_serializer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  tx_ready,
    output logic [BYTE_W-1:0]     tx_data,
    output logic                  tx_valid,
    output logic                  last_byte_accepted
);

    localparam int BPW = bytes_per_word(DATA_WIDTH);
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [DATA_WIDTH-1:0] shift_q;
    logic [CW-1:0]         cnt_q;
    logic                  valid_q;
    logic                  byte_acc;

    assign tx_data            = shift_q[BYTE_W-1:0];
    assign tx_valid           = valid_q;
    assign byte_acc           = valid_q && tx_ready;
    assign last_byte_accepted = byte_acc && (cnt_q == CW'(BPW - 1));

    // Load a fresh word, otherwise shift one byte out per accepted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            shift_q <= load_data;
            cnt_q   <= '0;
            valid_q <= 1'b1;
        end else if (byte_acc) begin
            shift_q <= shift_q >> BYTE_W;
            cnt_q   <= cnt_q + CW'(1);
            if (last_byte_accepted)
                valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: walks an inclusive (wrapping) address range, reads each
// word from a registered single-port memory and streams it out as bytes.
// Optional macro DUMP_CHECKSUM_EN appends an XOR checksum byte to the dump.
import mem_dump_pkg::*;

module mem_dump_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read_enable,
    output logic                  mem_write_enable,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic [BYTE_W-1:0]     tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_q;
    logic [ADDR_WIDTH-1:0] last_q;
    logic                  start_acc;
    logic                  last_acc;
    logic                  ser_valid;
    logic [BYTE_W-1:0]     ser_data;

    assign mem_write_enable = 1'b0;
    assign start_acc        = (state_q == IDLE) && start;

    word_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ser (
        .clk               (clk),
        .rst               (rst),
        .load              (state_q == WAIT),
        .load_data         (mem_data_out),
        .tx_ready          (tx_ready),
        .tx_data           (ser_data),
        .tx_valid          (ser_valid),
        .last_byte_accepted(last_acc)
    );

`ifdef DUMP_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q;

    // Running XOR of every data byte handed to the transmitter in this dump.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            csum_q <= '0;
        else if (start_acc)
            csum_q <= '0;
        else if (ser_valid && tx_ready)
            csum_q <= csum_q ^ ser_data;
    end

    assign tx_valid = ser_valid || (state_q == CSUM);
    assign tx_data  = (state_q == CSUM) ? csum_q : ser_data;
`else
    assign tx_valid = ser_valid;
    assign tx_data  = ser_data;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and decoded control outputs.
    always_comb begin
        state_d         = state_q;
        busy            = (state_q != IDLE);
        done            = 1'b0;
        mem_read_enable = 1'b0;
        unique case (state_q)
            IDLE: if (start) state_d = READ;
            READ: begin
                mem_read_enable = 1'b1;
                state_d         = WAIT;
            end
            WAIT: state_d = SEND;
            SEND: begin
                if (last_acc) begin
                    if (cur_q == last_q)
`ifdef DUMP_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    else
                        state_d = READ;
                end
            end
`ifdef DUMP_CHECKSUM_EN
            CSUM: if (tx_ready) state_d = DONE;
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Range tracking; mem_address only moves when a new READ is about to be issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q       <= '0;
            last_q      <= '0;
            mem_address <= '0;
        end else if (start_acc) begin
            cur_q       <= first_addr;
            last_q      <= last_addr;
            mem_address <= first_addr;
        end else if ((state_q == SEND) && last_acc && (cur_q != last_q)) begin
            cur_q       <= cur_q + 1'b1;
            mem_address <= cur_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader: table-driven and randomized dumps against a
// range/byte-list reference model; also reset, abort and start-while-busy.
module tb_mem_dump_reader;

    localparam int DW = 32;
    localparam int AW = 4;
`ifdef DUMP_CHECKSUM_EN
    localparam int CSUM_N = 1;
`else
    localparam int CSUM_N = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] first_addr, last_addr;
    logic          busy, done;
    logic [AW-1:0] mem_address;
    logic          mem_read_enable, mem_write_enable;
    logic [DW-1:0] mem_data_out;
    logic [7:0]    tx_data;
    logic          tx_valid, tx_ready;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    mem_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .first_addr      (first_addr),
        .last_addr       (last_addr),
        .busy            (busy),
        .done            (done),
        .mem_address     (mem_address),
        .mem_read_enable (mem_read_enable),
        .mem_write_enable(mem_write_enable),
        .mem_data_out    (mem_data_out),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memword(input logic [3:0] a);
        return 32'hA0B0C000 + {28'd0, a};
    endfunction

    // Registered-read memory model.
    always @(posedge clk)
        if (mem_read_enable) mem_data_out <= memword(mem_address);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Observation queues filled at the falling edge.
    logic [7:0] byte_q[$];
    int         byte_cyc_q[$];
    logic [3:0] rd_addr_q[$];
    int         rd_cyc_q[$];
    int         done_cyc_q[$];
    bit         prev_stall = 0;
    logic [7:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                chk("hold_valid", tx_valid, 1);
                chk("hold_data", tx_data, prev_data);
            end
            if (tx_valid && tx_ready) begin
                byte_q.push_back(tx_data);
                byte_cyc_q.push_back(cyc);
            end
            if (mem_read_enable) begin
                rd_addr_q.push_back(mem_address);
                rd_cyc_q.push_back(cyc);
            end
            if (done) done_cyc_q.push_back(cyc);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic clear_obs();
        byte_q.delete(); byte_cyc_q.delete();
        rd_addr_q.delete(); rd_cyc_q.delete(); done_cyc_q.delete();
    endtask

    // Entered and left at posedge+1. mode: 0 ready=1, 1 pattern 1,0,0, 2 random.
    task automatic run_dump(input logic [3:0] f, input logic [3:0] l, input int mode,
                            input bit inject, input int exp_words);
        int         words, t0, n;
        logic [7:0] exp_b[$];
        logic [3:0] exp_a[$];
        logic [7:0] x;
        logic [31:0] w;
        words = ((int'(l) - int'(f) + 16) % 16) + 1;
        x = 8'h00;
        for (int k = 0; k < words; k++) begin
            exp_a.push_back(4'((int'(f) + k) % 16));
            w = memword(4'((int'(f) + k) % 16));
            for (int j = 0; j < 4; j++) begin
                exp_b.push_back(w[8*j +: 8]);
                x ^= w[8*j +: 8];
            end
        end
        if (CSUM_N == 1) exp_b.push_back(x);

        clear_obs();
        first_addr = f; last_addr = l; start = 1'b1; tx_ready = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_cycle1", busy, 1);
        chk("write_enable_zero", mem_write_enable, 0);
        n = 1;
        while (done_cyc_q.size() == 0 && n < 2000) begin
            case (mode)
                0: tx_ready = 1'b1;
                1: tx_ready = (n % 3 == 1);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (inject && n == 2) begin
                start = 1'b1; first_addr = f + 4'd7; last_addr = f + 4'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0; tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", done_cyc_q.size(), 1);
        chk("busy_after", busy, 0);
        chk("word_count", rd_addr_q.size(), exp_words);
        chk("byte_count", byte_q.size(), exp_b.size());
        for (int i = 0; i < exp_a.size() && i < rd_addr_q.size(); i++)
            chk("read_addr", rd_addr_q[i], exp_a[i]);
        for (int i = 0; i < exp_b.size() && i < byte_q.size(); i++)
            chk("byte", byte_q[i], exp_b[i]);
        if (mode == 0) begin
            for (int k = 0; k < rd_cyc_q.size(); k++)
                chk("read_cycle", rd_cyc_q[k] - t0, 1 + 6 * k);
            for (int i = 0; i < byte_cyc_q.size() && i < 4 * words; i++)
                chk("byte_cycle", byte_cyc_q[i] - t0, 3 + 6 * (i / 4) + (i % 4));
            if (done_cyc_q.size() > 0)
                chk("done_cycle", done_cyc_q[0] - t0, 6 * words + 1 + CSUM_N);
        end
    endtask

    typedef struct {
        logic [3:0] f;
        logic [3:0] l;
        int         mode;
        bit         inject;
        int         words;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int   an;
        tbl[0] = '{4'd3,  4'd3, 0, 1'b0, 1};
        tbl[1] = '{4'd2,  4'd4, 0, 1'b0, 3};
        tbl[2] = '{4'd14, 4'd1, 0, 1'b0, 4};
        tbl[3] = '{4'd5,  4'd9, 1, 1'b0, 5};
        tbl[4] = '{4'd0,  4'd0, 0, 1'b1, 1};
        tbl[5] = '{4'd15, 4'd0, 2, 1'b1, 2};

        rst = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0; tx_ready = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_read_enable", mem_read_enable, 0);
        chk("rst_address", mem_address, 0);
        chk("rst_write_enable", mem_write_enable, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            run_dump(tbl[i].f, tbl[i].l, tbl[i].mode, tbl[i].inject, tbl[i].words);

        // Single word at address 0: the checksum byte, when present, is 00^C0^B0^A0.
        run_dump(4'd0, 4'd0, 0, 1'b0, 1);
`ifdef DUMP_CHECKSUM_EN
        if (byte_q.size() == 5) chk("csum_d0", byte_q[4], 8'hD0);
        else chk("csum_len", byte_q.size(), 5);
`else
        chk("no_csum_len", byte_q.size(), 4);
`endif

        // Abort during the second byte of a word, then a clean restart.
        clear_obs();
        first_addr = 4'd3; last_addr = 4'd3; start = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        an = 0;
        while (!(tx_valid && tx_data == 8'hC0) && an < 20) begin
            @(negedge clk);
            an++;
        end
        chk("abort_reached", an < 20, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_tx_valid", tx_valid, 0);
        chk("abort_tx_data", tx_data, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_read_enable", mem_read_enable, 0);
        chk("abort_address", mem_address, 0);
        done_cyc_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_cyc_q.size(), 0);
        run_dump(4'd3, 4'd3, 0, 1'b0, 1);

        // Randomized ranges and backpressure.
        for (int r = 0; r < 8; r++) begin
            logic [3:0] rf, rl;
            rf = 4'($urandom_range(0, 15));
            rl = 4'($urandom_range(0, 15));
            run_dump(rf, rl, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                     ((int'(rl) - int'(rf) + 16) % 16) + 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
